// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC owner, single-outstanding imem requester, DEPTH-entry queue.
// Optional FETCH_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int INC = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_pc_inc,
  input  logic              dec_ready,
  output logic              busy,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              out_q, out_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] epc_q [DEPTH];

  logic full, empty, accept, resp, take, byp, push, pop, bad_pc;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  assign imem_req  = !rst && !halt && !redirect && !out_q && !full;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_rdy;
  assign resp      = imem_valid && out_q;
  assign take      = resp && !drop_q && !redirect;
  assign bad_pc    = (INC == 2) && redirect_pc[0];

  always_comb begin
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = take && empty && dec_ready;
`endif
  end

  assign push = take && !byp;
  assign pop  = !empty && dec_ready && !redirect;

  assign dec_valid  = !empty || byp;
  assign dec_instr  = byp ? imem_data : instr_q[rd_q];
  assign dec_pc     = byp ? req_pc_q : epc_q[rd_q];
  assign dec_pc_inc = dec_pc + ADDR_W'(INC);
  assign busy       = out_q;
  assign err        = err_q;

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    err_d    = err_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    if ((imem_valid && !out_q) || (redirect && bad_pc)) err_d = 1'b1;
    if (redirect) begin
      pc_d  = redirect_pc;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      // a word landing this very edge is simply discarded; otherwise mark it for dropping
      if (out_q) begin
        out_d  = !imem_valid;
        drop_d = !imem_valid;
      end
    end else begin
      if (accept) begin
        pc_d     = pc_q + ADDR_W'(INC);
        req_pc_d = pc_q;
        out_d    = 1'b1;
      end
      if (resp) begin
        out_d  = 1'b0;
        drop_d = 1'b0;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_q[wr_q] <= imem_data;
      epc_q[wr_q]   <= req_pc_q;
    end
  end

endmodule
